// File: rtl/victim_cache_wb.sv
// victim_cache_wb: small fully associative victim cache behind the D-cache.
// Holds NUM_ENTRIES evicted lines with per-entry valid/dirty bits. The lookup
// is combinational and can hand the hit line back to the D-cache (take).
// Inserts fill the lowest free slot first and then go round-robin. A dirty
// line pushed out by an insert, and every dirty line on a flush, is written
// back to memory over a valid/ready port.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   flush_i                          flush request pulse
//   ins_valid_i/ins_ready_o          insert handshake (addr/data/dirty)
//   lkp_addr_i/lkp_take_i            lookup address, take the hit entry
//   lkp_hit_o/lkp_data_o/lkp_dirty_o lookup result ('0 on miss)
//   wb_valid_o/wb_ready_i            writeback handshake (addr/data)
//   busy_o                           controller not idle
module victim_cache_wb #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_BITS   = 28,
  parameter int NUM_ENTRIES = 4,
  parameter int PTR_BITS    = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ins_valid_i,
  output logic                  ins_ready_o,
  input  logic [ADDR_BITS-1:0]  ins_addr_i,
  input  logic [LINE_WIDTH-1:0] ins_data_i,
  input  logic                  ins_dirty_i,
  input  logic [ADDR_BITS-1:0]  lkp_addr_i,
  input  logic                  lkp_take_i,
  output logic                  lkp_hit_o,
  output logic [LINE_WIDTH-1:0] lkp_data_o,
  output logic                  lkp_dirty_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [ADDR_BITS-1:0]  wb_addr_o,
  output logic [LINE_WIDTH-1:0] wb_data_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, EVICT_WB = 2'd1, FLUSH = 2'd2} state_t;

  state_t                  state_r;
  logic [NUM_ENTRIES-1:0]  valid_r;
  logic [NUM_ENTRIES-1:0]  dirty_r;
  logic [ADDR_BITS-1:0]    addr_r [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]   data_r [NUM_ENTRIES];
  logic [PTR_BITS-1:0]     rr_ptr_r;
  logic [PTR_BITS-1:0]     idx_r;
  logic                    flush_pend_r;
  logic [ADDR_BITS-1:0]    pend_addr_r;
  logic [LINE_WIDTH-1:0]   pend_data_r;
  logic                    pend_dirty_r;

  logic                    hit_s, match_s, free_s;
  logic [PTR_BITS-1:0]     hit_idx_s, match_idx_s, free_idx_s, ins_tgt_s, wb_sel_s;
  logic                    idle_s, ins_fire_s, take_fire_s, take_same_s, take_clr_s;
  logic                    evict_s, wb_valid_s, flush_step_s;

  // Lowest-index priority search for the lookup hit, the insert match and the first free slot.
  always_comb begin
    hit_s       = 1'b0;
    hit_idx_s   = '0;
    match_s     = 1'b0;
    match_idx_s = '0;
    free_s      = 1'b0;
    free_idx_s  = '0;
    // Scanning downwards lets the lowest index overwrite any higher one.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_r[i] && (addr_r[i] == lkp_addr_i)) begin
        hit_s     = 1'b1;
        hit_idx_s = PTR_BITS'(i);
      end else begin
        hit_s     = hit_s;
      end
      if (valid_r[i] && (addr_r[i] == ins_addr_i)) begin
        match_s     = 1'b1;
        match_idx_s = PTR_BITS'(i);
      end else begin
        match_s     = match_s;
      end
      if (!valid_r[i]) begin
        free_s     = 1'b1;
        free_idx_s = PTR_BITS'(i);
      end else begin
        free_s     = free_s;
      end
    end
  end

  assign idle_s      = (state_r == IDLE);
  assign lkp_hit_o   = idle_s && hit_s;
  assign lkp_data_o  = lkp_hit_o ? data_r[hit_idx_s] : '0;
  assign lkp_dirty_o = lkp_hit_o && dirty_r[hit_idx_s];

  // ins_ready is held low while reset is asserted so every output reads 0.
  assign ins_ready_o = rst && idle_s && !flush_pend_r && !flush_i;
  assign ins_fire_s  = ins_valid_i && ins_ready_o;
  assign ins_tgt_s   = match_s ? match_idx_s : (free_s ? free_idx_s : rr_ptr_r);
  assign evict_s     = ins_fire_s && !match_s && !free_s && dirty_r[rr_ptr_r];

  // An insert aimed at the entry being taken wins; the take is then dropped.
  assign take_fire_s = lkp_take_i && lkp_hit_o;
  assign take_same_s = take_fire_s && ins_fire_s && (ins_tgt_s == hit_idx_s);
  assign take_clr_s  = take_fire_s && !take_same_s;

  // In FLUSH the scan index selects the entry; in EVICT_WB the victim is rr_ptr.
  assign wb_sel_s     = (state_r == FLUSH) ? idx_r : rr_ptr_r;
  assign flush_step_s = valid_r[idx_r] && dirty_r[idx_r];
  assign wb_valid_s   = (state_r == EVICT_WB) || ((state_r == FLUSH) && flush_step_s);
  assign wb_valid_o   = wb_valid_s;
  assign wb_addr_o    = wb_valid_s ? addr_r[wb_sel_s] : '0;
  assign wb_data_o    = wb_valid_s ? data_r[wb_sel_s] : '0;
  assign busy_o       = !idle_s;

  // Controller FSM together with the entry storage it updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      dirty_r      <= '0;
      rr_ptr_r     <= '0;
      idx_r        <= '0;
      flush_pend_r <= 1'b0;
      pend_addr_r  <= '0;
      pend_data_r  <= '0;
      pend_dirty_r <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (take_clr_s) begin
            valid_r[hit_idx_s] <= 1'b0;
            dirty_r[hit_idx_s] <= 1'b0;
          end
          if (ins_fire_s) begin
            if (evict_s) begin
              pend_addr_r  <= ins_addr_i;
              pend_data_r  <= ins_data_i;
              pend_dirty_r <= ins_dirty_i;
              state_r      <= EVICT_WB;
            end else begin
              addr_r[ins_tgt_s]  <= ins_addr_i;
              data_r[ins_tgt_s]  <= ins_data_i;
              valid_r[ins_tgt_s] <= 1'b1;
              dirty_r[ins_tgt_s] <= (match_s && !take_same_s) ?
                                    (dirty_r[ins_tgt_s] | ins_dirty_i) : ins_dirty_i;
              if (!match_s && !free_s) begin
                rr_ptr_r <= rr_ptr_r + PTR_BITS'(1);
              end
            end
          end
          if (flush_i) begin
            state_r <= FLUSH;
            idx_r   <= '0;
          end
        end
        EVICT_WB: begin
          if (flush_i) begin
            flush_pend_r <= 1'b1;
          end
          if (wb_ready_i) begin
            addr_r[rr_ptr_r]  <= pend_addr_r;
            data_r[rr_ptr_r]  <= pend_data_r;
            valid_r[rr_ptr_r] <= 1'b1;
            dirty_r[rr_ptr_r] <= pend_dirty_r;
            rr_ptr_r          <= rr_ptr_r + PTR_BITS'(1);
            idx_r             <= '0;
            state_r           <= (flush_pend_r || flush_i) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          // Clean or invalid entries take one cycle; dirty ones wait for ready.
          if (!flush_step_s || wb_ready_i) begin
            if (idx_r == PTR_BITS'(NUM_ENTRIES - 1)) begin
              valid_r      <= '0;
              dirty_r      <= '0;
              rr_ptr_r     <= '0;
              flush_pend_r <= 1'b0;
              state_r      <= IDLE;
            end else begin
              idx_r <= idx_r + PTR_BITS'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache_wb.sv
// Self-checking bench for victim_cache_wb: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_victim_cache_wb;

  localparam int LW = 128;
  localparam int AB = 28;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [AB-1:0] ins_addr = '0;
  logic [LW-1:0] ins_data = '0;
  logic          ins_dirty = 1'b0;
  logic [AB-1:0] lkp_addr = '0;
  logic          lkp_take = 1'b0;
  logic          lkp_hit;
  logic [LW-1:0] lkp_data;
  logic          lkp_dirty;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [AB-1:0] wb_addr;
  logic [LW-1:0] wb_data;
  logic          busy;

  always #5 clk = ~clk;

  victim_cache_wb #(.LINE_WIDTH(LW), .ADDR_BITS(AB), .NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .ins_valid_i(ins_valid), .ins_ready_o(ins_ready), .ins_addr_i(ins_addr),
    .ins_data_i(ins_data), .ins_dirty_i(ins_dirty),
    .lkp_addr_i(lkp_addr), .lkp_take_i(lkp_take), .lkp_hit_o(lkp_hit),
    .lkp_data_o(lkp_data), .lkp_dirty_o(lkp_dirty),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr),
    .wb_data_o(wb_data), .busy_o(busy)
  );

  // Reference model: entry contents plus a queue of outstanding controller
  // steps (one eviction writeback, or one step per scanned flush entry).
  typedef struct {
    bit            wb;
    bit            ev;
    logic [AB-1:0] a;
    logic [LW-1:0] d;
  } step_t;

  step_t         q[$];
  bit            mv[N];
  bit            md[N];
  logic [AB-1:0] ma[N];
  logic [LW-1:0] mdat[N];
  int            mrr;
  bit            fpend;
  logic [AB-1:0] pa;
  logic [LW-1:0] pd;
  bit            pdirty;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [AB-1:0] seen[$];
  int            busy_cnt;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_addr(input logic [AB-1:0] a);
    for (int i = 0; i < N; i++) if (mv[i] && ma[i] == a) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < N; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0; ma[i] = '0; mdat[i] = '0;
    end
    mrr = 0; fpend = 1'b0; q.delete();
  endtask

  task automatic build_flush();
    for (int i = 0; i < N; i++) q.push_back('{mv[i] && md[i], 1'b0, ma[i], mdat[i]});
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic step_cycle();
    int  h, m, f, t;
    bit  bsy, rdy, ins, take, evict, ewb;
    @(negedge clk);
    bsy = (q.size() != 0);
    h   = bsy ? -1 : find_addr(lkp_addr);
    rdy = !bsy && !flush;
    ewb = bsy && q[0].wb;
    check("lkp_hit", LW'(lkp_hit), LW'(h >= 0));
    check("lkp_data", lkp_data, (h >= 0) ? mdat[h] : '0);
    check("lkp_dirty", LW'(lkp_dirty), LW'((h >= 0) && md[h]));
    check("ins_ready", LW'(ins_ready), LW'(rdy));
    check("busy", LW'(busy), LW'(bsy));
    check("wb_valid", LW'(wb_valid), LW'(ewb));
    check("wb_addr", LW'(wb_addr), ewb ? LW'(q[0].a) : '0);
    check("wb_data", wb_data, ewb ? q[0].d : '0);
    if (bsy) busy_cnt++;
    if (wb_valid && wb_ready) seen.push_back(wb_addr);

    if (!bsy) begin
      take = lkp_take && (h >= 0);
      ins  = ins_valid && rdy;
      t = -1; m = -1; f = -1; evict = 1'b0;
      if (ins) begin
        m = find_addr(ins_addr);
        f = find_free();
        if (m >= 0) t = m;
        else if (f >= 0) t = f;
        else begin
          t = mrr;
          evict = md[mrr];
        end
      end
      if (take && h != t) begin
        mv[h] = 1'b0; md[h] = 1'b0;
      end
      if (ins) begin
        if (evict) begin
          pa = ins_addr; pd = ins_data; pdirty = ins_dirty;
          q.push_back('{1'b1, 1'b1, ma[t], mdat[t]});
        end else begin
          md[t]   = (m >= 0 && !(take && h == t)) ? (md[t] | ins_dirty) : ins_dirty;
          mv[t]   = 1'b1;
          ma[t]   = ins_addr;
          mdat[t] = ins_data;
          if (m < 0 && f < 0) mrr = (mrr + 1) % N;
        end
      end
      if (flush) build_flush();
    end else if (q[0].ev) begin
      if (flush) fpend = 1'b1;
      if (wb_ready) begin
        mv[mrr] = 1'b1; md[mrr] = pdirty; ma[mrr] = pa; mdat[mrr] = pd;
        mrr = (mrr + 1) % N;
        void'(q.pop_front());
        if (fpend) begin
          fpend = 1'b0;
          build_flush();
        end
      end
    end else begin
      if (!q[0].wb || wb_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          for (int i = 0; i < N; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
          mrr = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; ins_valid = 1'b0; lkp_take = 1'b0; ins_dirty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_wb_valid", LW'(wb_valid), '0);
    check("rst_busy", LW'(busy), '0);
    check("rst_ins_ready", LW'(ins_ready), '0);
    check("rst_lkp_hit", LW'(lkp_hit), '0);
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [AB-1:0] a, input logic [LW-1:0] d, input bit dirty);
    ins_valid = 1'b1; ins_addr = a; ins_data = d; ins_dirty = dirty;
    step_cycle();
    ins_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [AB-1:0] a, input bit hit,
                      input logic [LW-1:0] d, input bit dirty);
    lkp_addr = a;
    #1;
    check({tag, "_hit"}, LW'(lkp_hit), LW'(hit));
    check({tag, "_data"}, lkp_data, d);
    check({tag, "_dirty"}, LW'(lkp_dirty), LW'(dirty));
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();
    check("post_rst_ins_ready", LW'(ins_ready), LW'(1));

    // Four clean inserts, then hit and miss lookups.
    for (int i = 0; i < 4; i++) insert(AB'(28'h10 + i), LW'(8'hA0 + i), 1'b0);
    look("hit12", 28'h12, 1'b1, LW'(8'hA2), 1'b0);
    look("miss20", 28'h20, 1'b0, '0, 1'b0);

    // Full of clean lines: the next insert replaces entry 0 without a writeback.
    insert(28'h20, LW'(8'hB0), 1'b0);
    check("clean_repl_wb", LW'(wb_valid), '0);
    look("miss10", 28'h10, 1'b0, '0, 1'b0);
    look("hit20", 28'h20, 1'b1, LW'(8'hB0), 1'b0);

    // Dirty victim: writeback held stable while ready is low.
    do_reset();
    for (int i = 0; i < 4; i++) insert(AB'(28'h10 + i), LW'(8'hC0 + i), 1'b1);
    wb_ready = 1'b0;
    insert(28'h30, LW'(8'hD0), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check("ev_wb_valid", LW'(wb_valid), LW'(1));
      check("ev_wb_addr", LW'(wb_addr), LW'(28'h10));
      check("ev_ins_ready", LW'(ins_ready), '0);
      check("ev_busy", LW'(busy), LW'(1));
    end
    wb_ready = 1'b1;
    step_cycle();
    wb_ready = 1'b0;
    look("hit30", 28'h30, 1'b1, LW'(8'hD0), 1'b0);
    insert(28'h31, LW'(8'hD1), 1'b0);
    check("rr_next_victim", LW'(wb_addr), LW'(28'h11));
    wb_ready = 1'b1;
    step_cycle();

    // Flush writes back only the dirty entries, scanning all four slots.
    do_reset();
    insert(28'h10, LW'(8'hE0), 1'b1);
    insert(28'h11, LW'(8'hE1), 1'b0);
    insert(28'h12, LW'(8'hE2), 1'b1);
    wb_ready = 1'b1;
    flush = 1'b1;
    step_cycle();
    flush = 1'b0;
    seen.delete();
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) step_cycle();
    check("flush_wb_count", LW'(seen.size()), LW'(2));
    if (seen.size() == 2) begin
      check("flush_wb0", LW'(seen[0]), LW'(28'h10));
      check("flush_wb1", LW'(seen[1]), LW'(28'h12));
    end
    check("flush_busy_cycles", LW'(busy_cnt), LW'(4));
    for (int i = 0; i < 3; i++) look("post_flush", AB'(28'h10 + i), 1'b0, '0, 1'b0);

    // Clean re-insert keeps the dirty bit; take then frees the slot for reuse.
    do_reset();
    insert(28'h11, LW'(8'hF0), 1'b1);
    insert(28'h11, LW'(8'hF1), 1'b0);
    look("merge11", 28'h11, 1'b1, LW'(8'hF1), 1'b1);
    lkp_take = 1'b1;
    step_cycle();
    lkp_take = 1'b0;
    look("taken11", 28'h11, 1'b0, '0, 1'b0);
    insert(28'h15, LW'(8'hF5), 1'b0);
    look("reuse15", 28'h15, 1'b1, LW'(8'hF5), 1'b0);

    // Reset in the middle of an eviction drops everything.
    do_reset();
    for (int i = 0; i < 4; i++) insert(AB'(28'h10 + i), LW'(8'h50 + i), 1'b1);
    wb_ready = 1'b0;
    insert(28'h30, LW'(8'h60), 1'b1);
    check("pre_rst_busy", LW'(busy), LW'(1));
    lkp_addr = 28'h30;
    do_reset();
    look("lost30", 28'h30, 1'b0, '0, 1'b0);
    look("lost10", 28'h10, 1'b0, '0, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ins_valid = ($urandom_range(0, 1) == 0);
      ins_addr  = AB'(28'h10 + $urandom_range(0, 7));
      ins_data  = {$urandom, $urandom, $urandom, $urandom};
      ins_dirty = ($urandom_range(0, 1) == 0);
      lkp_addr  = AB'(28'h10 + $urandom_range(0, 7));
      lkp_take  = ($urandom_range(0, 2) == 0);
      wb_ready  = ($urandom_range(0, 1) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      step_cycle();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
